logic_unit_arbiter: RTL and testbench

//  Shares one 64-bit bitwise logic datapath (AND/OR/XOR/ANDN) between two requesters.

---
 rtl/logic_unit_arbiter.sv | 105 ++++++++++
 tb/tb_logic_unit_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// Two-requester arbiter sharing one bitwise logic datapath (AND/OR/XOR/ANDN)
// with a single registered result slot and valid/ready handshakes on all sides.
module logic_unit_arbiter #(
  parameter int unsigned WIDTH      = 64,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_s,
  output logic             res_id
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       state_reg, state_next;
  logic [WIDTH-1:0] res_s_reg, res_s_next;
  logic             res_id_reg, res_id_next;
  logic             prio_reg, prio_next;

  logic             can_accept;
  logic             xfer0, xfer1, xfer_any;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH-1:0] op_result;

  assign res_valid = (state_reg == ST_FULL);
  assign res_s     = res_s_reg;
  assign res_id    = res_id_reg;

  // The slot can take a new op when empty or when its occupant leaves this cycle.
  assign can_accept = !res_valid | res_ready;
  assign req0_ready = can_accept & (!prio_reg | !req1_valid);
  assign req1_ready = can_accept & (prio_reg | !req0_valid);

  assign xfer0    = req0_valid & req0_ready;
  assign xfer1    = req1_valid & req1_ready;
  assign xfer_any = xfer0 | xfer1;

  assign sel_op = xfer1 ? req1_op : req0_op;
  assign sel_a  = xfer1 ? req1_a  : req0_a;
  assign sel_b  = xfer1 ? req1_b  : req0_b;

  genvar gi;
  generate
    for (gi = 0; gi < int'(WIDTH); gi++) begin : g_bit
      assign op_result[gi] = sel_op[1]
                           ? (sel_op[0] ? (sel_a[gi] & ~sel_b[gi]) : (sel_a[gi] ^ sel_b[gi]))
                           : (sel_op[0] ? (sel_a[gi] |  sel_b[gi]) : (sel_a[gi] & sel_b[gi]));
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    res_s_next  = res_s_reg;
    res_id_next = res_id_reg;
    prio_next   = prio_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (xfer_any) begin
          state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        if (res_ready && !xfer_any) begin
          state_next = ST_EMPTY;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
    if (xfer_any) begin
      res_s_next  = op_result;
      res_id_next = xfer1;
      // The requester just served yields the next tie.
      prio_next   = FIXED_PRIO ? 1'b0 : ~xfer1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_EMPTY;
      res_s_reg  <= '0;
      res_id_reg <= 1'b0;
      prio_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      res_s_reg  <= res_s_next;
      res_id_reg <= res_id_next;
      prio_reg   <= prio_next;
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench: instance 0 is round-robin, instance 1 is fixed priority; both are
// compared every cycle against a transaction-level model of the result slot.
module tb_logic_unit_arbiter;

  localparam logic [63:0] A_PAT = 64'hF0F0F0F0F0F0F0F0;
  localparam logic [63:0] B_PAT = 64'hFF00FF00FF00FF00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v0 [2];
  logic        v1 [2];
  logic [1:0]  op0 [2];
  logic [1:0]  op1 [2];
  logic [63:0] a0 [2];
  logic [63:0] a1 [2];
  logic [63:0] b0 [2];
  logic [63:0] b1 [2];
  logic        rr [2];
  logic        rdy0 [2];
  logic        rdy1 [2];
  logic        rv [2];
  logic [63:0] rs [2];
  logic        rid [2];

  // Behavioural model of each instance
  logic        m_valid [2];
  logic [63:0] m_s [2];
  logic        m_id [2];
  logic        m_prio [2];
  logic        xf0 [2];
  logic        xf1 [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.WIDTH(64), .FIXED_PRIO(1'b0)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0[0]), .req0_ready(rdy0[0]), .req0_op(op0[0]), .req0_a(a0[0]), .req0_b(b0[0]),
    .req1_valid(v1[0]), .req1_ready(rdy1[0]), .req1_op(op1[0]), .req1_a(a1[0]), .req1_b(b1[0]),
    .res_valid(rv[0]), .res_ready(rr[0]), .res_s(rs[0]), .res_id(rid[0])
  );

  logic_unit_arbiter #(.WIDTH(64), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0[1]), .req0_ready(rdy0[1]), .req0_op(op0[1]), .req0_a(a0[1]), .req0_b(b0[1]),
    .req1_valid(v1[1]), .req1_ready(rdy1[1]), .req1_op(op1[1]), .req1_a(a1[1]), .req1_b(b1[1]),
    .res_valid(rv[1]), .res_ready(rr[1]), .res_s(rs[1]), .res_id(rid[1])
  );

  function automatic logic [63:0] f(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return a & ~b;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0;
      m_s[k]     = '0;
      m_id[k]    = 1'b0;
      m_prio[k]  = 1'b0;
      xf0[k]     = 1'b0;
      xf1[k]     = 1'b0;
    end
  endtask

  task automatic idle(input int k);
    v0[k] = 1'b0; v1[k] = 1'b0; op0[k] = 2'd0; op1[k] = 2'd0;
    a0[k] = '0; b0[k] = '0; a1[k] = '0; b1[k] = '0; rr[k] = 1'b1;
  endtask

  // Compare at the falling edge, then advance the model over the rising edge.
  task automatic step();
    logic        n_valid [2];
    logic [63:0] n_s [2];
    logic        n_id [2];
    logic        n_prio [2];
    logic        slot_free, want0, want1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      slot_free = !m_valid[k] || rr[k];
      // A requester is offered the slot if it is free and the other side cannot claim the tie.
      want0 = slot_free && (!v1[k] || m_prio[k] == 1'b0);
      want1 = slot_free && (!v0[k] || m_prio[k] == 1'b1);
      check($sformatf("i%0d_req0_ready", k), 64'(rdy0[k]), 64'(want0));
      check($sformatf("i%0d_req1_ready", k), 64'(rdy1[k]), 64'(want1));
      check($sformatf("i%0d_res_valid", k),  64'(rv[k]),   64'(m_valid[k]));
      check($sformatf("i%0d_res_s", k),      rs[k],        m_s[k]);
      check($sformatf("i%0d_res_id", k),     64'(rid[k]),  64'(m_id[k]));
      xf0[k]    = v0[k] && want0;
      xf1[k]    = v1[k] && want1;
      n_valid[k] = m_valid[k];
      n_s[k]     = m_s[k];
      n_id[k]    = m_id[k];
      n_prio[k]  = m_prio[k];
      if (xf0[k] || xf1[k]) begin
        n_valid[k] = 1'b1;
        n_s[k]     = xf1[k] ? f(op1[k], a1[k], b1[k]) : f(op0[k], a0[k], b0[k]);
        n_id[k]    = xf1[k];
        n_prio[k]  = (k == 1) ? 1'b0 : !xf1[k];
      end else if (rr[k]) begin
        n_valid[k] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = n_valid[k];
      m_s[k]     = n_s[k];
      m_id[k]    = n_id[k];
      m_prio[k]  = n_prio[k];
    end
  endtask

  // New random request only once the previous one on that port was taken.
  task automatic rand_drive(input int k);
    if (!v0[k] || xf0[k]) begin
      v0[k] = ($urandom_range(0, 3) != 0);
      op0[k] = 2'($urandom);
      a0[k] = {$urandom, $urandom};
      b0[k] = {$urandom, $urandom};
    end
    if (!v1[k] || xf1[k]) begin
      v1[k] = ($urandom_range(0, 3) != 0);
      op1[k] = 2'($urandom);
      a1[k] = {$urandom, $urandom};
      b1[k] = {$urandom, $urandom};
    end
    rr[k] = ($urandom_range(0, 3) != 0);
  endtask

  logic [63:0] exp2 [3];
  logic [1:0]  op2 [3];

  initial begin
    rst_n = 1'b0;
    idle(0);
    idle(1);
    mreset();
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("i%0d_reset_valid", k), 64'(rv[k]), 64'd0);
      check($sformatf("i%0d_reset_s", k), rs[k], 64'd0);
      check($sformatf("i%0d_reset_id", k), 64'(rid[k]), 64'd0);
    end
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single AND from req0
    v0[0] = 1'b1; op0[0] = 2'd0; a0[0] = A_PAT; b0[0] = B_PAT;
    step();
    check("t1_valid", 64'(rv[0]), 64'd1);
    check("t1_s", rs[0], 64'hF000F000F000F000);
    check("t1_id", 64'(rid[0]), 64'd0);
    v0[0] = 1'b0;

    // OR/XOR/ANDN from req1, back-to-back
    op2[0] = 2'd1; op2[1] = 2'd2; op2[2] = 2'd3;
    exp2[0] = 64'hFFF0FFF0FFF0FFF0;
    exp2[1] = 64'h0FF00FF00FF00FF0;
    exp2[2] = 64'h00F000F000F000F0;
    for (int i = 0; i < 3; i++) begin
      v1[0] = 1'b1; op1[0] = op2[i]; a1[0] = A_PAT; b1[0] = B_PAT;
      step();
      check($sformatf("t2_s%0d", i), rs[0], exp2[i]);
      check($sformatf("t2_id%0d", i), 64'(rid[0]), 64'd1);
    end

    // Tie for 6 cycles alternates
    v0[0] = 1'b1; op0[0] = 2'd0; a0[0] = A_PAT; b0[0] = B_PAT;
    v1[0] = 1'b1; op1[0] = 2'd2; a1[0] = A_PAT; b1[0] = B_PAT;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("t3_id%0d", i), 64'(rid[0]), 64'(i % 2));
    end

    // Stalled consumer holds the result, then same-edge drain and load
    v0[0] = 1'b0; v1[0] = 1'b1; op1[0] = 2'd1; rr[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t4_hold_valid%0d", i), 64'(rv[0]), 64'd1);
      check($sformatf("t4_hold_s%0d", i), rs[0], 64'h0FF00FF00FF00FF0);
      check($sformatf("t4_hold_id%0d", i), 64'(rid[0]), 64'd1);
    end
    rr[0] = 1'b1;
    step();
    check("t4_load_valid", 64'(rv[0]), 64'd1);
    check("t4_load_s", rs[0], 64'hFFF0FFF0FFF0FFF0);
    check("t4_load_id", 64'(rid[0]), 64'd1);

    // Asynchronous reset while full, then tie restarts with req0
    v1[0] = 1'b0; rr[0] = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 64'(rv[0]), 64'd0);
    check("t5_rst_s", rs[0], 64'd0);
    mreset();
    #1 rst_n = 1'b1;
    v0[0] = 1'b1; op0[0] = 2'd0; v1[0] = 1'b1; op1[0] = 2'd2; rr[0] = 1'b1;
    step();
    check("t5_first_id", 64'(rid[0]), 64'd0);
    check("t5_first_s", rs[0], 64'hF000F000F000F000);
    step();
    check("t5_second_id", 64'(rid[0]), 64'd1);
    idle(0);

    // Fixed priority: req0 always wins ties
    v0[1] = 1'b1; op0[1] = 2'd0; a0[1] = A_PAT; b0[1] = B_PAT;
    v1[1] = 1'b1; op1[1] = 2'd2; a1[1] = A_PAT; b1[1] = B_PAT;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t6_id%0d", i), 64'(rid[1]), 64'd0);
    end
    v0[1] = 1'b0;
    step();
    check("t6_req1_id", 64'(rid[1]), 64'd1);
    check("t6_req1_s", rs[1], 64'h0FF00FF00FF00FF0);

    // Randomized traffic on both instances
    for (int n = 0; n < 600; n++) begin
      rand_drive(0);
      rand_drive(1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
